// File: rtl/cardinal_local_port.sv
// Router-side local port toward the NIC: polarity-based two-VC handshake with
// one-entry injection and ejection buffers per VC.
module cardinal_local_port #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              polarity,
    input  logic              nic_so,
    output logic              nic_ro,
    input  logic [DATA_W-1:0] nic_do,
    output logic              nic_si,
    input  logic              nic_ri,
    output logic [DATA_W-1:0] nic_di,
    output logic              inj_vld,
    input  logic              inj_rdy,
    output logic [DATA_W-1:0] inj_data,
    input  logic              ej_vld,
    output logic              ej_rdy,
    input  logic [DATA_W-1:0] ej_data,
    output logic              vc_err,
    output logic [CNT_W-1:0]  inj_cnt,
    output logic [CNT_W-1:0]  ej_cnt
);

    logic [1:0][DATA_W-1:0] inj_buf, ej_buf;
    logic [1:0]             inj_full, ej_full;

    // NIC side always works on VC ~polarity, core side on VC polarity.
    logic core_vc, nic_vc;
    assign core_vc = polarity;
    assign nic_vc  = ~polarity;

    assign nic_ro   = ~inj_full[nic_vc];
    assign inj_vld  = inj_full[core_vc];
    assign inj_data = inj_buf[core_vc];
    assign ej_rdy   = ~ej_full[core_vc];
    assign nic_si   = ej_full[nic_vc] & nic_ri;
    assign nic_di   = ej_buf[nic_vc];

    logic nic_acc, nic_ok, inj_drain, ej_acc, ej_ok;
    assign nic_acc   = nic_so & nic_ro;
    assign nic_ok    = (nic_do[DATA_W-1] == nic_vc);
    assign inj_drain = inj_vld & inj_rdy;
    assign ej_acc    = ej_vld & ej_rdy;
    assign ej_ok     = (ej_data[DATA_W-1] == core_vc);

    always_ff @(posedge clk) begin
        if (reset) begin
            polarity <= 1'b0;
            inj_buf  <= '0;
            ej_buf   <= '0;
            inj_full <= '0;
            ej_full  <= '0;
            vc_err   <= 1'b0;
            inj_cnt  <= '0;
            ej_cnt   <= '0;
        end else begin
            polarity <= ~polarity;
            // Each event below touches a distinct index, so all may fire together.
            if (nic_acc) begin
                if (nic_ok) begin
                    inj_buf[nic_vc]  <= nic_do;
                    inj_full[nic_vc] <= 1'b1;
                end else begin
                    vc_err <= 1'b1;
                end
            end
            if (inj_drain) begin
                inj_full[core_vc] <= 1'b0;
                inj_cnt           <= inj_cnt + 1'b1;
            end
            if (ej_acc) begin
                if (ej_ok) begin
                    ej_buf[core_vc]  <= ej_data;
                    ej_full[core_vc] <= 1'b1;
                end else begin
                    vc_err <= 1'b1;
                end
            end
            if (nic_si) begin
                ej_full[nic_vc] <= 1'b0;
                ej_cnt          <= ej_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cardinal_local_port.sv
// Directed per-cycle vector table plus hand sequences for fill/reset recovery.
module tb_cardinal_local_port;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              polarity;
    logic              nic_so, nic_ro, nic_si, nic_ri;
    logic [DATA_W-1:0] nic_do, nic_di;
    logic              inj_vld, inj_rdy, ej_vld, ej_rdy, vc_err;
    logic [DATA_W-1:0] inj_data, ej_data;
    logic [CNT_W-1:0]  inj_cnt, ej_cnt;

    cardinal_local_port #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .polarity(polarity),
        .nic_so(nic_so), .nic_ro(nic_ro), .nic_do(nic_do),
        .nic_si(nic_si), .nic_ri(nic_ri), .nic_di(nic_di),
        .inj_vld(inj_vld), .inj_rdy(inj_rdy), .inj_data(inj_data),
        .ej_vld(ej_vld), .ej_rdy(ej_rdy), .ej_data(ej_data),
        .vc_err(vc_err), .inj_cnt(inj_cnt), .ej_cnt(ej_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        so;
        logic [63:0] d;
        logic        ri, irdy, ev;
        logic [63:0] ed;
        logic        pol, ro, si;
        logic [63:0] di;
        logic        ivld;
        logic [63:0] idata;
        logic        erdy, err;
        logic [15:0] icnt, ecnt;
    } vec_t;

    localparam logic [63:0] Z = 64'h0;
    localparam logic [63:0] A = 64'h8000_0000_0000_00AA;
    localparam logic [63:0] B = 64'h0000_0000_0000_00BB;
    localparam logic [63:0] C = 64'h8000_0000_0000_0055;
    localparam logic [63:0] D = 64'h0000_0000_0000_0066;
    localparam logic [63:0] E = 64'h8000_0000_0000_0011;

    int passed = 0;
    int total  = 0;

    function automatic vec_t mk(input logic so, input logic [63:0] d,
                                input logic ri, input logic irdy, input logic ev,
                                input logic [63:0] ed, input logic pol, input logic ro,
                                input logic si, input logic [63:0] di, input logic ivld,
                                input logic [63:0] idata, input logic erdy, input logic err,
                                input logic [15:0] icnt, input logic [15:0] ecnt);
        vec_t v;
        v.so = so; v.d = d; v.ri = ri; v.irdy = irdy; v.ev = ev; v.ed = ed;
        v.pol = pol; v.ro = ro; v.si = si; v.di = di; v.ivld = ivld;
        v.idata = idata; v.erdy = erdy; v.err = err; v.icnt = icnt; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic so, input logic [63:0] d, input logic ri,
                         input logic irdy, input logic ev, input logic [63:0] ed);
        nic_so = so; nic_do = d; nic_ri = ri; inj_rdy = irdy; ej_vld = ev; ej_data = ed;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vt[21];

    initial begin
        vt[0]  = mk(0,Z,0,0,0,Z, 0,1,0,Z,0,Z,1,0,0,0);
        vt[1]  = mk(0,Z,0,0,0,Z, 1,1,0,Z,0,Z,1,0,0,0);
        vt[2]  = mk(0,Z,0,0,0,Z, 0,1,0,Z,0,Z,1,0,0,0);
        vt[3]  = mk(0,Z,0,0,0,Z, 1,1,0,Z,0,Z,1,0,0,0);
        vt[4]  = mk(1,A,0,0,0,Z, 0,1,0,Z,0,Z,1,0,0,0);
        vt[5]  = mk(0,Z,0,1,0,Z, 1,1,0,Z,1,A,1,0,0,0);
        vt[6]  = mk(1,E,0,0,0,Z, 0,1,0,Z,0,Z,1,0,1,0);
        vt[7]  = mk(1,B,0,0,0,Z, 1,1,0,Z,1,E,1,0,1,0);
        vt[8]  = mk(1,B,0,0,0,Z, 0,0,0,Z,1,B,1,0,1,0);
        vt[9]  = mk(1,B,0,0,0,Z, 1,0,0,Z,1,E,1,0,1,0);
        vt[10] = mk(0,Z,0,1,0,Z, 0,0,0,Z,1,B,1,0,1,0);
        vt[11] = mk(0,Z,0,1,0,Z, 1,1,0,Z,1,E,1,0,2,0);
        vt[12] = mk(0,Z,0,0,0,Z, 0,1,0,Z,0,B,1,0,3,0);
        vt[13] = mk(0,Z,0,0,1,C, 1,1,0,Z,0,E,1,0,3,0);
        vt[14] = mk(0,Z,0,0,0,Z, 0,1,0,C,0,B,1,0,3,0);
        vt[15] = mk(0,Z,1,0,0,Z, 1,1,0,Z,0,E,0,0,3,0);
        vt[16] = mk(0,Z,1,0,0,Z, 0,1,1,C,0,B,1,0,3,0);
        vt[17] = mk(0,Z,0,0,0,Z, 1,1,0,Z,0,E,1,0,3,1);
        vt[18] = mk(1,B,0,0,0,Z, 0,1,0,C,0,B,1,0,3,1);
        vt[19] = mk(0,Z,0,0,1,D, 1,1,0,Z,0,E,1,1,3,1);
        vt[20] = mk(0,Z,0,0,0,Z, 0,1,0,C,0,B,1,1,3,1);

        reset = 1'b1;
        drive(0, Z, 0, 0, 0, Z);
        step();
        step();
        reset = 1'b0;

        foreach (vt[i]) begin
            drive(vt[i].so, vt[i].d, vt[i].ri, vt[i].irdy, vt[i].ev, vt[i].ed);
            #1;
            chk($sformatf("v%0d.pol", i),   {63'd0, polarity}, {63'd0, vt[i].pol});
            chk($sformatf("v%0d.ro", i),    {63'd0, nic_ro},   {63'd0, vt[i].ro});
            chk($sformatf("v%0d.si", i),    {63'd0, nic_si},   {63'd0, vt[i].si});
            chk($sformatf("v%0d.di", i),    nic_di,            vt[i].di);
            chk($sformatf("v%0d.ivld", i),  {63'd0, inj_vld},  {63'd0, vt[i].ivld});
            chk($sformatf("v%0d.idata", i), inj_data,          vt[i].idata);
            chk($sformatf("v%0d.erdy", i),  {63'd0, ej_rdy},   {63'd0, vt[i].erdy});
            chk($sformatf("v%0d.err", i),   {63'd0, vc_err},   {63'd0, vt[i].err});
            chk($sformatf("v%0d.icnt", i),  {48'd0, inj_cnt},  {48'd0, vt[i].icnt});
            chk($sformatf("v%0d.ecnt", i),  {48'd0, ej_cnt},   {48'd0, vt[i].ecnt});
            step();
        end

        // Fill all four buffers across two cycles (polarity 1 then 0).
        drive(1, B, 0, 0, 1, C);
        #1;
        chk("fill1.pol",  {63'd0, polarity}, 64'd1);
        chk("fill1.erdy", {63'd0, ej_rdy},   64'd1);
        chk("fill1.ro",   {63'd0, nic_ro},   64'd1);
        step();
        drive(1, A, 0, 0, 1, D);
        #1;
        chk("fill2.ro",   {63'd0, nic_ro},   64'd1);
        chk("fill2.erdy", {63'd0, ej_rdy},   64'd1);
        step();
        drive(0, Z, 0, 0, 0, Z);
        #1;
        chk("full.ro",    {63'd0, nic_ro},   64'd0);
        chk("full.erdy",  {63'd0, ej_rdy},   64'd0);
        chk("full.ivld",  {63'd0, inj_vld},  64'd1);
        chk("full.idata", inj_data,          A);
        chk("full.di",    nic_di,            D);

        // Reset mid-transfer discards everything.
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1, A, 1, 0, 0, Z);
        #1;
        chk("rst.pol",   {63'd0, polarity}, 64'd0);
        chk("rst.ro",    {63'd0, nic_ro},   64'd1);
        chk("rst.erdy",  {63'd0, ej_rdy},   64'd1);
        chk("rst.ivld",  {63'd0, inj_vld},  64'd0);
        chk("rst.idata", inj_data,          Z);
        chk("rst.si",    {63'd0, nic_si},   64'd0);
        chk("rst.di",    nic_di,            Z);
        chk("rst.err",   {63'd0, vc_err},   64'd0);
        chk("rst.icnt",  {48'd0, inj_cnt},  64'd0);
        chk("rst.ecnt",  {48'd0, ej_cnt},   64'd0);
        step();
        drive(0, Z, 0, 1, 0, Z);
        #1;
        chk("resume.ivld",  {63'd0, inj_vld}, 64'd1);
        chk("resume.idata", inj_data,         A);
        step();
        drive(0, Z, 0, 0, 0, Z);
        #1;
        chk("resume.icnt", {48'd0, inj_cnt}, 64'd1);
        chk("resume.ro",   {63'd0, nic_ro},  64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
